data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/dmem_lane_ram.sv | 41 ++++
 rtl/data_mem_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory controller: access-mode encodings,
// FSM state type, lane geometry and the alignment check used at acceptance.
// -----------------------------------------------------------------------------
package dmem_pkg;

  // Byte lanes per 32-bit word and the width of a lane index (addr[1:0]).
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  typedef enum logic [1:0] {
    MODE_BYTE = 2'b00,
    MODE_HALF = 2'b01,
    MODE_WORD = 2'b10,
    MODE_RSVD = 2'b11
  } access_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // An access is bad when it is not naturally aligned or uses the reserved
  // encoding. Bad accesses still complete, but with err and without effect.
  function automatic logic is_bad_access(input access_mode_e mode,
                                         input logic [LANE_W-1:0] lane);
    logic bad;
    case (mode)
      MODE_BYTE: bad = 1'b0;
      MODE_HALF: bad = lane[0];
      MODE_WORD: bad = |lane;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// -----------------------------------------------------------------------------
// dmem_lane_ram
// Word-addressed storage built from four independent byte-wide arrays, so a
// store can update any subset of lanes. Synchronous write, asynchronous read.
//
// Ports
//   clk      in   clock for the write port
//   i_we     in   per-lane write enable (bit n writes byte lane n)
//   i_idx    in   word index shared by the read and write ports
//   i_wdata  in   lane-aligned write data
//   o_rdata  out  word at i_idx (combinational)
// -----------------------------------------------------------------------------
module dmem_lane_ram
  import dmem_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic                   clk,
  input  logic [NUM_LANES-1:0]   i_we,
  input  logic [IDX_W-1:0]       i_idx,
  input  logic [8*NUM_LANES-1:0] i_wdata,
  output logic [8*NUM_LANES-1:0] o_rdata
);

  localparam int DEPTH = 1 << IDX_W;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [7:0] r_mem [DEPTH];

    // NOTE: the array has no reset branch; clearing it would need a
    // multi-cycle sweep or turn it into flops, and contents must survive rst.
    always_ff @(posedge clk) begin
      if (i_we[g]) begin
        r_mem[i_idx] <= i_wdata[8*g +: 8];
      end
    end

    assign o_rdata[8*g +: 8] = r_mem[i_idx];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Data-memory controller for a simple core. Accepts one access in IDLE,
// holds it for WAIT_STATES cycles, then completes it in RESP with a one-cycle
// ack. Stores commit at the RESP edge; loads are read and extended during
// RESP. Misaligned or reserved accesses complete with err and no effect.
//
// Ports
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   req          in   access request (held while stall is high)
//   we           in   1 = store, 0 = load
//   addr         in   byte address (bits above ADDR_WIDTH-1 ignored)
//   wdata        in   right-aligned store data
//   access_mode  in   00 byte, 01 half, 10 word, 11 reserved
//   ld_unsigned  in   1 = zero-extend loads, 0 = sign-extend
//   rdata        out  load result, valid with ack, otherwise 0
//   stall        out  req & ~ack
//   ack          out  one-cycle completion strobe
//   err          out  qualifies ack: access was misaligned or reserved
// -----------------------------------------------------------------------------
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  access_mode,
  input  logic        ld_unsigned,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        ack,
  output logic        err
);

  localparam int         IDX_W     = ADDR_WIDTH - 2;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  // FSM, wait counter and latched request
  state_e              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [IDX_W-1:0]    r_idx;
  logic [LANE_W-1:0]   r_lane;
  logic [31:0]         r_wdata;
  access_mode_e        r_mode;
  logic                r_uns;
  logic                r_bad;
  logic                r_ack;
  logic                r_err;

  logic                w_bad_in;
  logic [NUM_LANES-1:0] w_be;
  logic [NUM_LANES-1:0] w_lane_we;
  logic [31:0]         w_wlanes;
  logic [31:0]         w_rword;
  logic [31:0]         w_load;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;

  // Upper address bits are deliberately dropped so accesses wrap around.
  if (ADDR_WIDTH < 32) begin : g_unused_addr
    logic w_unused_hi;
    assign w_unused_hi = ^addr[31:ADDR_WIDTH];
  end

  assign w_bad_in = is_bad_access(access_mode_e'(access_mode), addr[1:0]);

  // NOTE: sequential state uses <= only, so every flop samples the values
  // from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_lane  <= '0;
      r_wdata <= '0;
      r_mode  <= MODE_BYTE;
      r_uns   <= 1'b0;
      r_bad   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          if (req) begin
            r_we    <= we;
            r_idx   <= addr[ADDR_WIDTH-1:2];
            r_lane  <= addr[1:0];
            r_wdata <= wdata;
            r_mode  <= access_mode_e'(access_mode);
            r_uns   <= ld_unsigned;
            r_bad   <= w_bad_in;
            r_cnt   <= '0;
            if (WAIT_STATES == 0) begin
              // No wait phase: the latched copy is not visible yet, so the
              // error flag comes straight from the inputs.
              r_state <= RESP;
              r_ack   <= 1'b1;
              r_err   <= w_bad_in;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == WAIT_LAST) begin
            r_state <= RESP;
            r_ack   <= 1'b1;
            r_err   <= r_bad;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign ack   = r_ack;
  assign err   = r_err;
  assign stall = req & ~r_ack;

  // Store aligner: replicate the data across lanes and enable only the
  // lanes the access covers.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_be     = '0;
    w_wlanes = '0;
    case (r_mode)
      MODE_BYTE: begin
        w_be     = 4'b0001 << r_lane;
        w_wlanes = {4{r_wdata[7:0]}};
      end
      MODE_HALF: begin
        w_be     = r_lane[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{r_wdata[15:0]}};
      end
      MODE_WORD: begin
        w_be     = 4'b1111;
        w_wlanes = r_wdata;
      end
      default: begin
        w_be     = '0;
        w_wlanes = '0;
      end
    endcase
  end

  // r_ack is high exactly in RESP, so the write lands on the RESP edge. A
  // reset in RESP clears r_ack asynchronously and the write is dropped.
  assign w_lane_we = (r_ack && r_we && !r_err) ? w_be : '0;

  dmem_lane_ram #(
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_lane_we),
    .i_idx   (r_idx),
    .i_wdata (w_wlanes),
    .o_rdata (w_rword)
  );

  // Load extractor: pick the addressed lane(s), then sign/zero extend.
  always_comb begin
    w_byte = '0;
    w_half = '0;
    w_load = '0;
    case (r_mode)
      MODE_BYTE: begin
        w_byte = w_rword[{r_lane, 3'b000} +: 8];
        w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
      end
      MODE_HALF: begin
        w_half = r_lane[1] ? w_rword[31:16] : w_rword[15:0];
        w_load = {{16{~r_uns & w_half[15]}}, w_half};
      end
      MODE_WORD: begin
        w_load = w_rword;
      end
      default: begin
        w_load = '0;
      end
    endcase
  end

  // Only a successful load drives data; stores, errors and idle show 0.
  assign rdata = (r_ack && !r_err && !r_we) ? w_load : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Self-checking bench for data_mem_ctrl. Two instances share stimulus: u_dut_a
// (WAIT_STATES=2) and u_dut_b (WAIT_STATES=0); sel routes req to one of them.
// Expected responses are queued when an access is driven and compared when
// the selected instance acks.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  localparam logic [1:0] M_BYTE = 2'b00;
  localparam logic [1:0] M_HALF = 2'b01;
  localparam logic [1:0] M_WORD = 2'b10;
  localparam logic [1:0] M_RSVD = 2'b11;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  mode;
  logic        uns;

  logic        req_a, req_b;
  logic [31:0] rdata_a, rdata_b;
  logic        stall_a, stall_b, ack_a, ack_b, err_a, err_b;
  logic [31:0] o_rdata;
  logic        o_stall, o_ack, o_err;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  assign req_a   = req & ~sel;
  assign req_b   = req & sel;
  assign o_rdata = sel ? rdata_b : rdata_a;
  assign o_stall = sel ? stall_b : stall_a;
  assign o_ack   = sel ? ack_b   : ack_a;
  assign o_err   = sel ? err_b   : err_a;

  data_mem_ctrl #(.ADDR_WIDTH(12), .WAIT_STATES(2)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .req         (req_a),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .access_mode (mode),
    .ld_unsigned (uns),
    .rdata       (rdata_a),
    .stall       (stall_a),
    .ack         (ack_a),
    .err         (err_a)
  );

  data_mem_ctrl #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .req         (req_b),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .access_mode (mode),
    .ld_unsigned (uns),
    .rdata       (rdata_b),
    .stall       (stall_b),
    .ack         (ack_b),
    .err         (err_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One complete access on the selected instance. Inputs are scrambled while
  // the access is in WAIT to show the latched copy is used.
  task automatic do_access(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] m,
                           input logic u, input logic [31:0] exp_rd,
                           input logic exp_err);
    int   cycles;
    int   stalls;
    int   exp_lat;
    logic seen;
    logic quiet;
    exp_t e;
    exp_lat = sel ? 1 : 3;
    @(negedge clk);
    we = w; addr = a; wdata = d; mode = m; uns = u; req = 1'b1;
    sb.push_back('{exp_rd, exp_err});
    cycles = 0; stalls = 0; seen = 1'b0; quiet = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (o_ack) begin
        seen = 1'b1;
      end else begin
        cycles++;
        if (o_stall) stalls++;
        if (o_err || o_rdata != 32'd0) quiet = 1'b0;
        if (i == 1) begin
          we = ~w; addr = ~a; wdata = ~d; mode = ~m; uns = ~u;
        end
      end
    end
    check({tag, " ack_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(cycles), 32'(exp_lat));
    check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_lat));
    check({tag, " stall_at_ack"}, 32'(o_stall), 32'd0);
    check({tag, " quiet_before_ack"}, 32'(quiet), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " rdata"}, o_rdata, e.rdata);
      check({tag, " err"}, 32'(o_err), 32'(e.err));
    end else begin
      check({tag, " scoreboard_empty"}, 32'(sb.size()), 32'd1);
    end
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic any_ack;
    int   k;
    exp_t e;
    rst = 1'b1; req = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    mode = M_WORD; uns = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset ack", 32'(ack_a), 32'd0);
    check("reset err", 32'(err_a), 32'd0);
    check("reset rdata", rdata_a, 32'd0);
    check("reset stall_low", 32'(stall_a), 32'd0);
    req = 1'b1;
    #1;
    check("reset stall_follows_req", 32'(stall_a), 32'd1);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Word store / load, then byte lanes and extension
    do_access("st_w_10", 1'b1, 32'h10, 32'hDEADBEEF, M_WORD, 1'b0, 32'h0, 1'b0);
    do_access("ld_w_10", 1'b0, 32'h10, 32'h0, M_WORD, 1'b0, 32'hDEADBEEF, 1'b0);
    do_access("st_b_13", 1'b1, 32'h13, 32'h00000080, M_BYTE, 1'b0, 32'h0, 1'b0);
    do_access("ld_b_13s", 1'b0, 32'h13, 32'h0, M_BYTE, 1'b0, 32'hFFFFFF80, 1'b0);
    do_access("ld_b_13u", 1'b0, 32'h13, 32'h0, M_BYTE, 1'b1, 32'h00000080, 1'b0);
    do_access("ld_w_10b", 1'b0, 32'h10, 32'h0, M_WORD, 1'b0, 32'h80ADBEEF, 1'b0);

    // Misaligned / reserved accesses
    do_access("ld_h_11", 1'b0, 32'h11, 32'h0, M_HALF, 1'b0, 32'h0, 1'b1);
    do_access("st_w_12", 1'b1, 32'h12, 32'h55555555, M_WORD, 1'b0, 32'h0, 1'b1);
    do_access("ld_r_10", 1'b0, 32'h10, 32'h0, M_RSVD, 1'b0, 32'h0, 1'b1);
    do_access("st_r_10", 1'b1, 32'h10, 32'h66666666, M_RSVD, 1'b0, 32'h0, 1'b1);
    do_access("ld_w_10c", 1'b0, 32'h10, 32'h0, M_WORD, 1'b0, 32'h80ADBEEF, 1'b0);

    // Half-word lanes
    do_access("ld_h_12s", 1'b0, 32'h12, 32'h0, M_HALF, 1'b0, 32'hFFFF80AD, 1'b0);
    do_access("ld_h_12u", 1'b0, 32'h12, 32'h0, M_HALF, 1'b1, 32'h000080AD, 1'b0);
    do_access("st_h_10", 1'b1, 32'h10, 32'hAAAA5566, M_HALF, 1'b0, 32'h0, 1'b0);
    do_access("ld_w_10d", 1'b0, 32'h10, 32'h0, M_WORD, 1'b0, 32'h80AD5566, 1'b0);
    do_access("ld_b_11u", 1'b0, 32'h11, 32'h0, M_BYTE, 1'b1, 32'h00000055, 1'b0);

    // Reset during WAIT aborts a store
    do_access("st_w_20", 1'b1, 32'h20, 32'hCAFEF00D, M_WORD, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h11111111; mode = M_WORD; req = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_wait ack", 32'(ack_a), 32'd0);
    check("rst_wait err", 32'(err_a), 32'd0);
    check("rst_wait rdata", rdata_a, 32'd0);
    check("rst_wait stall_follows_req", 32'(stall_a), 32'd1);
    any_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (ack_a) any_ack = 1'b1;
    end
    req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (ack_a) any_ack = 1'b1;
    end
    check("rst_wait no_ack", 32'(any_ack), 32'd0);
    do_access("ld_w_20", 1'b0, 32'h20, 32'h0, M_WORD, 1'b0, 32'hCAFEF00D, 1'b0);

    // Address wrap-around
    do_access("st_w_1004", 1'b1, 32'h1004, 32'h12345678, M_WORD, 1'b0, 32'h0, 1'b0);
    do_access("ld_w_0004", 1'b0, 32'h0004, 32'h0, M_WORD, 1'b0, 32'h12345678, 1'b0);

    // Zero-wait instance: prefill, then back-to-back loads with req held
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_access("b_fill", 1'b1, 32'h40 + 32'(4 * i), 32'hA5C30000 + 32'(i * 17),
                M_WORD, 1'b0, 32'h0, 1'b0);
    end
    @(negedge clk);
    we = 1'b0; mode = M_WORD; uns = 1'b0; addr = 32'h40; req = 1'b1;
    sb.push_back('{32'hA5C30000, 1'b0});
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("b2b ack_pattern_%0d", i), 32'(o_ack), 32'(i % 2));
      if (o_ack) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check($sformatf("b2b rdata_%0d", k), o_rdata, e.rdata);
          check($sformatf("b2b err_%0d", k), 32'(o_err), 32'(e.err));
        end
        k++;
        if (k < 4) begin
          addr = 32'h40 + 32'(4 * k);
          sb.push_back('{32'hA5C30000 + 32'(k * 17), 1'b0});
        end else begin
          req = 1'b0;
        end
      end
    end
    req = 1'b0;
    check("b2b ack_count", 32'(k), 32'd4);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
